// File: rtl/mem_access_ctrl_if.sv
// Bundle between the load/store requester, the sequencer and the
// four-lane byte memory.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [3:0]        mem_cs;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic [7:0]        mem_data_0;
  logic [7:0]        mem_data_1;
  logic [7:0]        mem_data_2;
  logic [7:0]        mem_data_3;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata,
    input  mem_data_0, mem_data_1, mem_data_2, mem_data_3,
    output req_ready, resp_valid, resp_rdata,
    output mem_cs, mem_addr, mem_wdata, mem_write
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata,
    output mem_data_0, mem_data_1, mem_data_2, mem_data_3,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_cs, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a four-lane segmented byte memory;
// splits word-crossing accesses into two phases and extends loads.
module mem_access_ctrl #(
  parameter int ADDR_W = 7
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] W_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, PH1, PH2, CAP, RESP
  } state_t;

  state_t state, nxt;

  logic              we;
  logic              uns;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       byte_buf;
  logic [3:0]        last_cs;

  logic [1:0]      lane;
  logic [WA_W-1:0] w0;
  logic [WA_W-1:0] w1;
  logic [7:0]      nmask;
  logic [7:0]      span;
  logic            split;
  logic [63:0]     wrot;
  logic [63:0]     rrot;
  logic [31:0]     rd;
  logic [31:0]     ext;

  logic            ready;
  logic            rvalid;
  logic [31:0]     rdata;
  logic [3:0]      cs;
  logic [WA_W-1:0] maddr;
  logic [31:0]     mwdata;
  logic            mwrite;

  assign lane  = addr[1:0];
  assign w0    = addr[ADDR_W-1:2];
  assign w1    = w0 + W_ONE;
  // span[3:0] is phase-1 lanes, span[7:4] spills into the next word
  assign span  = nmask << lane;
  assign split = |span[7:4];
  assign wrot  = {wdata, wdata} << {lane, 3'b000};
  assign rrot  = {byte_buf, byte_buf} >> {lane, 3'b000};
  assign rd    = rrot[31:0];

  always_comb begin
    nmask = 8'h0f;
    ext   = rd;
    unique case (size)
      2'b00: begin
        nmask = 8'h01;
        ext   = {{24{rd[7] & ~uns}}, rd[7:0]};
      end
      2'b01: begin
        nmask = 8'h03;
        ext   = {{16{rd[15] & ~uns}}, rd[15:0]};
      end
      default: begin
        nmask = 8'h0f;
        ext   = rd;
      end
    endcase
  end

  always_comb begin
    nxt    = state;
    ready  = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    cs     = '0;
    maddr  = '0;
    mwdata = '0;
    mwrite = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) nxt = PH1;
      end
      PH1: begin
        cs     = span[3:0];
        maddr  = w0;
        mwdata = wrot[63:32];
        mwrite = we;
        if (split)   nxt = PH2;
        else if (we) nxt = RESP;
        else         nxt = CAP;
      end
      PH2: begin
        cs     = span[7:4];
        maddr  = w1;
        mwdata = wrot[63:32];
        mwrite = we;
        nxt    = we ? RESP : CAP;
      end
      CAP: nxt = RESP;
      RESP: begin
        rvalid = 1'b1;
        rdata  = we ? 32'h0 : ext;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = rvalid;
  assign bus.resp_rdata = rdata;
  assign bus.mem_cs     = cs;
  assign bus.mem_addr   = maddr;
  assign bus.mem_wdata  = mwdata;
  assign bus.mem_write  = mwrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we       <= 1'b0;
      uns      <= 1'b0;
      size     <= 2'b00;
      addr     <= '0;
      wdata    <= '0;
      byte_buf <= '0;
      last_cs  <= '0;
    end else begin
      state   <= nxt;
      last_cs <= cs;
      if (state == IDLE && bus.req_valid) begin
        we    <= bus.req_we;
        uns   <= bus.req_unsigned;
        size  <= bus.req_size;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
      end
      // read data lags its chip select by one cycle
      if ((state == PH2 || state == CAP) && !we) begin
        if (last_cs[0]) byte_buf[7:0]   <= bus.mem_data_0;
        if (last_cs[1]) byte_buf[15:8]  <= bus.mem_data_1;
        if (last_cs[2]) byte_buf[23:16] <= bus.mem_data_2;
        if (last_cs[3]) byte_buf[31:24] <= bus.mem_data_3;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a four-lane byte
// memory model; directed vectors with hand-computed responses.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_access_ctrl_if #(.ADDR_W(7)) bus ();

  mem_access_ctrl #(.ADDR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  cs;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        wr;
    logic [31:0] cyc;
  } ph_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] cyc;
  } rs_t;

  ph_t ph_q[$];
  rs_t rs_q[$];

  logic [7:0] mem [4][32];
  logic [7:0] rdl [4];

  initial begin
    for (int l = 0; l < 4; l++) begin
      rdl[l] = 8'h00;
      for (int w = 0; w < 32; w++) mem[l][w] = 8'(4 * w + l);
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus.mem_cs[l]) begin
        if (bus.mem_write)
          mem[l][bus.mem_addr] <= bus.mem_wdata[8*l +: 8];
        else
          rdl[l] <= mem[l][bus.mem_addr];
      end
    end
  end

  assign bus.mem_data_0 = rdl[0];
  assign bus.mem_data_1 = rdl[1];
  assign bus.mem_data_2 = rdl[2];
  assign bus.mem_data_3 = rdl[3];

  always @(negedge clk) begin : mon
    ph_t pe, pa;
    rs_t re, ra;
    if (!rst) begin
      if (bus.mem_cs != 4'b0 || bus.mem_write) begin
        pa = '{bus.mem_cs, bus.mem_addr, bus.mem_wdata,
               bus.mem_write, 32'(cyc)};
        n_chk++;
        if (ph_q.size() == 0) begin
          n_fail++;
          $display("FAIL phase_unexpected got cs=%b addr=%0d cyc=%0d",
                   pa.cs, pa.addr, cyc);
        end else begin
          pe = ph_q.pop_front();
          if (pa !== pe) begin
            n_fail++;
            $display("FAIL phase got cs=%b a=%0d wd=%h w=%b c=%0d %s",
                     pa.cs, pa.addr, pa.wd, pa.wr, pa.cyc, "");
            $display("FAIL phase want cs=%b a=%0d wd=%h w=%b c=%0d",
                     pe.cs, pe.addr, pe.wd, pe.wr, pe.cyc);
          end
        end
      end
      if (bus.resp_valid) begin
        ra = '{bus.resp_rdata, 32'(cyc)};
        n_chk++;
        if (rs_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected got rdata=%h cyc=%0d",
                   ra.rdata, cyc);
        end else begin
          re = rs_q.pop_front();
          if (ra !== re) begin
            n_fail++;
            $display("FAIL resp got rdata=%h cyc=%0d want %h cyc=%0d",
                     ra.rdata, ra.cyc, re.rdata, re.cyc);
          end
        end
      end
    end
  end

  task automatic issue(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [6:0]  a,
    input  logic [31:0] wd,
    input  logic [31:0] exp_rd,
    input  int          lat,
    input  logic [3:0]  cs1,
    input  logic [4:0]  a1,
    input  logic [3:0]  cs2,
    input  logic [4:0]  a2,
    input  logic [31:0] ewd,
    input  bit          abort,
    output int          c0
  );
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout addr=%h got ready=0 want 1", a);
    end
    c0 = cyc;
    ph_q.push_back('{cs1, a1, ewd, we, 32'(c0 + 1)});
    if (!abort) begin
      if (cs2 != 4'b0)
        ph_q.push_back('{cs2, a2, ewd, we, 32'(c0 + 2)});
      rs_q.push_back('{exp_rd, 32'(c0 + lat)});
    end
    @(posedge clk);
  endtask

  localparam logic [75:0] RST_OUT = {1'b1, 75'b0};

  initial begin
    int c0, c0b;
    logic [75:0] o;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (2) @(negedge clk);
    o = {bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.mem_cs,
         bus.mem_addr, bus.mem_wdata, bus.mem_write};
    n_chk++;
    if (o !== RST_OUT) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", o, RST_OUT);
    end
    rst = 1'b0;

    issue(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 32'h0, 2,
          4'b1111, 2, 4'b0, 0, 32'hDEADBEEF, 0, c0);
    issue(0, 2'b00, 0, 7'h0B, 32'h0, 32'hFFFFFFDE, 3,
          4'b1000, 2, 4'b0, 0, 32'h0, 0, c0);
    issue(0, 2'b00, 1, 7'h0B, 32'h0, 32'h000000DE, 3,
          4'b1000, 2, 4'b0, 0, 32'h0, 0, c0);
    issue(1, 2'b10, 0, 7'h06, 32'h11223344, 32'h0, 3,
          4'b1100, 1, 4'b0011, 2, 32'h33441122, 0, c0);
    issue(0, 2'b10, 0, 7'h06, 32'h0, 32'h11223344, 4,
          4'b1100, 1, 4'b0011, 2, 32'h0, 0, c0);
    issue(1, 2'b01, 0, 7'h7F, 32'h0000ABCD, 32'h0, 3,
          4'b1000, 31, 4'b0001, 0, 32'hCD0000AB, 0, c0);
    issue(0, 2'b01, 0, 7'h7F, 32'h0, 32'hFFFFABCD, 4,
          4'b1000, 31, 4'b0001, 0, 32'h0, 0, c0);
    issue(0, 2'b01, 1, 7'h0A, 32'h0, 32'h0000DEAD, 3,
          4'b1100, 2, 4'b0, 0, 32'h0, 0, c0);

    issue(1, 2'b10, 0, 7'h20, 32'h01020304, 32'h0, 2,
          4'b1111, 8, 4'b0, 0, 32'h01020304, 0, c0);
    issue(1, 2'b01, 0, 7'h31, 32'h00005566, 32'h0, 2,
          4'b0110, 12, 4'b0, 0, 32'h00556600, 0, c0b);
    n_chk++;
    if (c0b != c0 + 3) begin
      n_fail++;
      $display("FAIL busy_accept got c%0d want c%0d", c0b, c0 + 3);
    end
    issue(0, 2'b11, 0, 7'h20, 32'h0, 32'h01020304, 3,
          4'b1111, 8, 4'b0, 0, 32'h0, 0, c0);
    issue(0, 2'b00, 0, 7'h20, 32'h0, 32'h00000004, 3,
          4'b0001, 8, 4'b0, 0, 32'h0, 0, c0);
    issue(0, 2'b01, 1, 7'h31, 32'h0, 32'h00005566, 3,
          4'b0110, 12, 4'b0, 0, 32'h0, 0, c0);

    issue(1, 2'b10, 0, 7'h0D, 32'hCAFEF00D, 32'h0, 0,
          4'b1110, 3, 4'b0, 0, 32'hFEF00DCA, 1, c0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    o = {bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.mem_cs,
         bus.mem_addr, bus.mem_wdata, bus.mem_write};
    n_chk++;
    if (o !== RST_OUT) begin
      n_fail++;
      $display("FAIL mid_reset got %h want %h", o, RST_OUT);
    end
    @(negedge clk);
    rst = 1'b0;

    issue(0, 2'b10, 0, 7'h0C, 32'h0, 32'hFEF00D0C, 3,
          4'b1111, 3, 4'b0, 0, 32'h0, 0, c0);
    issue(0, 2'b10, 0, 7'h10, 32'h0, 32'h13121110, 3,
          4'b1111, 4, 4'b0, 0, 32'h0, 0, c0);
    @(negedge clk);
    bus.req_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if (ph_q.size() == 0 && rs_q.size() == 0) break;
      @(negedge clk);
    end
    n_chk++;
    if (ph_q.size() != 0 || rs_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d phases %0d resps pending want 0",
               ph_q.size(), rs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the CPU load/store path and the four-bank segmented byte memory (4 lanes × 32 words × 8 bit).

- Accepts one byte, halfword or word request at a byte address.
- Generates per-lane chip selects, the word address, the lane-rotated write data and the write strobe.
- Splits accesses that cross a word boundary into two memory phases.
- Assembles read data with sign or zero extension and returns a single-cycle response.

## Interface
Parameters:
- ADDR_W, 7, byte-address width (word address = ADDR_W-2 = 5 bits, 32 words)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  extended load data; 0 for stores
- mem_cs  out  4  per-lane chip select
- mem_addr  out  5  word address
- mem_wdata  out  32  lane l gets bits [8l+7:8l]
- mem_write  out  1  write strobe, shared by all lanes
- mem_data_0..mem_data_3  in  8 each  lane read data, valid the cycle after that lane's cs

## Operation
- States: IDLE, PH1, PH2, CAP, RESP.
- IDLE: req_ready=1. On req_valid, latch we, size, unsigned, addr and wdata, then go to PH1.
- Decode from the latched request:
  - n = 1/2/4 bytes.
  - lane = addr[1:0], w0 = addr[6:2], w1 = (w0+1) mod 32; word 31 wraps to 0.
  - Byte k lives at lane (lane+k) mod 4.
  - Split when lane+n > 4.
- PH1:
  - mem_addr=w0.
  - mem_cs = lanes lane..min(lane+n-1,3).
  - mem_write=we.
  - mem_wdata = wdata rotated left by 8·lane.
  - Next state: PH2 if split; else CAP for loads, RESP for stores.
- PH2:
  - mem_addr=w1, mem_cs = lanes 0..(lane+n-5), same mem_wdata and mem_write.
  - Loads capture the phase-1 lanes from mem_data_x into the byte buffer.
  - Next state: CAP for loads, RESP for stores.
- CAP: memory signals idle; capture the lanes selected in the previous phase.
- RESP:
  - resp_valid=1.
  - resp_rdata = buffer rotated right by 8·lane, truncated to n bytes, then extended per req_unsigned (word ignores extension).
  - Next state: IDLE.
- Outside PH1/PH2: mem_cs=0, mem_write=0, mem_addr=0, mem_wdata=0.
- req_valid outside IDLE is ignored; the requester must hold it until accepted.
- No response backpressure: resp_valid is a single-cycle pulse.

## Timing
- All outputs are registered or decoded from state plus latched registers; no combinational path from req_* to mem_*.
- Latency (accept cycle = c0, resp_valid asserted in cycle shown):
  - aligned store: c2
  - split store: c3
  - aligned load: c3
  - split load: c4
- Throughput: next accept is the cycle after RESP.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_cs=0, mem_addr=0, mem_wdata=0, mem_write=0, buffer=0.
- Reset mid-operation: immediate return to IDLE with the outputs above and no response. Any phase-1 bytes already written stay written.
- A byte access never splits; a halfword splits only at lane 3; a word splits at any lane≠0.

## Test plan
- Aligned word store 0xDEADBEEF at 0x08 -> PH1: mem_cs=1111, mem_addr=2, mem_wdata=0xDEADBEEF, mem_write=1; resp_valid at c2 with rdata=0.
- Then byte load at 0x0B, signed -> PH1 mem_cs=1000, mem_write=0; resp_rdata=0xFFFFFFDE at c3. Same load unsigned -> 0x000000DE.
- Split word store 0x11223344 at 0x06:
  - PH1: mem_addr=1, mem_cs=1100, mem_wdata=0x33441122.
  - PH2: mem_addr=2, mem_cs=0011, same mem_wdata.
  - Then word load at 0x06 -> 0x11223344 at c4.
- Wrap-around halfword store 0xABCD at 0x7F:
  - PH1: mem_addr=31, mem_cs=1000, mem_wdata=0xCD0000AB.
  - PH2: mem_addr=0, mem_cs=0001.
  - Signed halfword load at 0x7F -> 0xFFFFABCD.
- Request during busy: second req_valid held from c1 -> not accepted until IDLE (c3 for an aligned store); its parameters are then latched correctly.
- rst asserted during PH2 of a split store -> outputs at reset values the same cycle, no resp_valid; next request behaves normally. Phase-1 lanes hold new data, phase-2 lanes hold old data.
